// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with prefix absorption
// Filters the PS/2 clock, assembles 11-bit frames and emits one event per make/break code.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       ps2_clk_s,
  input  logic       ps2_data_s,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int TOW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]     FLT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     flt_cnt_q, flt_cnt_d;
  logic           clk_f_q, clk_f_d;
  logic [7:0]     shift_q, shift_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic           par_q, par_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           ext_pend_q, ext_pend_d;
  logic           brk_pend_q, brk_pend_d;
  logic [7:0]     scan_q, scan_d;
  logic           brk_out_q, brk_out_d;
  logic           ext_out_q, ext_out_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           fall;
  logic           timeout_hit;
  logic           frame_good;

  // Glitch filter: clk_f follows ps2_clk_s only after FILTER_LEN stable mismatched cycles.
  always_comb begin
    flt_cnt_d = '0;
    clk_f_d   = clk_f_q;
    if (ps2_clk_s != clk_f_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        clk_f_d = ps2_clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 8'd1;
      end
    end
  end

  assign fall        = clk_f_q & ~clk_f_d;
  assign timeout_hit = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_LAST);
  assign frame_good  = ps2_data_s & (^{shift_q, par_q});

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fall && !ps2_data_s) state_d = S_DATA;
      S_DATA:   if (fall && bit_cnt_q == 4'd7) state_d = S_PARITY;
      S_PARITY: if (fall) state_d = S_STOP;
      S_STOP:   if (fall) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_IDLE;
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    scan_d     = scan_q;
    brk_out_d  = brk_out_q;
    ext_out_d  = ext_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    busy_d     = (state_q != S_IDLE);
    to_cnt_d   = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          if (!ps2_data_s) begin
            shift_d   = '0;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (fall) par_d = ps2_data_s;
      end
      S_STOP: begin
        // Prefix bytes only arm a flag; the next ordinary byte consumes both flags.
        if (fall) begin
          if (!frame_good) begin
            err_d      = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_pend_d = 1'b1;
          end else begin
            scan_d     = shift_q;
            ext_out_d  = ext_pend_q;
            brk_out_d  = brk_pend_q;
            valid_d    = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end
      end
      default: ;
    endcase

    if (timeout_hit) begin
      err_d      = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      flt_cnt_q  <= '0;
      clk_f_q    <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      scan_q     <= '0;
      brk_out_q  <= 1'b0;
      ext_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      flt_cnt_q  <= flt_cnt_d;
      clk_f_q    <= clk_f_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      scan_q     <= scan_d;
      brk_out_q  <= brk_out_d;
      ext_out_q  <= ext_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign scan_code   = scan_q;
  assign code_valid  = valid_q;
  assign is_break    = brk_out_q;
  assign is_extended = ext_out_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;

endmodule
